// File: rtl/stream_demux_1to2.sv
// stream_demux_1to2
// Registered 1-to-2 valid/ready stream demultiplexer. Each upstream word is
// steered by select_i into one of two independent 2-entry FIFOs, so a stalled
// consumer never blocks traffic bound for the other output. ready_o depends
// only on the FIFO count registers and select_i; there is no combinational
// path from either downstream ready to ready_o.
//
// Optional feature: define STREAM_DEMUX_STATS_EN to add the saturating
// per-output delivery counters cnt0_o / cnt1_o.

module stream_demux_1to2 #(
    parameter int size = 32
) (
    input  logic            clk_i,
    input  logic            rst_i,
    input  logic [size-1:0] data_i,
    input  logic            valid_i,
    input  logic            select_i,
    output logic            ready_o,
    output logic [size-1:0] data0_o,
    output logic            valid0_o,
    input  logic            ready0_i,
    output logic [size-1:0] data1_o,
    output logic            valid1_o,
    input  logic            ready1_i
`ifdef STREAM_DEMUX_STATS_EN
    ,
    output logic [15:0]     cnt0_o,
    output logic [15:0]     cnt1_o
`endif
);

    // Output 0 FIFO state
    logic [size-1:0] mem0_r [2];
    logic            wr0_r;
    logic            rd0_r;
    logic [1:0]      count0_r;

    // Output 1 FIFO state
    logic [size-1:0] mem1_r [2];
    logic            wr1_r;
    logic            rd1_r;
    logic [1:0]      count1_r;

    // Handshake decode
    logic            full0_s;
    logic            full1_s;
    logic            ready_s;
    logic            push0_s;
    logic            push1_s;
    logic            pop0_s;
    logic            pop1_s;

    // Decode acceptance and per-output push/pop strobes from the count registers.
    // A full FIFO refuses a word even if it pops this cycle (no bypass path).
    always_comb begin
        full0_s = (count0_r == 2'd2);
        full1_s = (count1_r == 2'd2);
        if (select_i) begin
            ready_s = !full1_s;
        end else begin
            ready_s = !full0_s;
        end
        push0_s = valid_i && ready_s && !select_i;
        push1_s = valid_i && ready_s &&  select_i;
        pop0_s  = (count0_r != 2'd0) && ready0_i;
        pop1_s  = (count1_r != 2'd0) && ready1_i;
    end

    // Output 0 FIFO: storage, wrapping pointers and occupancy count.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            mem0_r[0] <= '0;
            mem0_r[1] <= '0;
            wr0_r     <= 1'b0;
            rd0_r     <= 1'b0;
            count0_r  <= 2'd0;
        end else begin
            if (push0_s) begin
                mem0_r[wr0_r] <= data_i;
                wr0_r         <= ~wr0_r;
            end
            if (pop0_s) begin
                rd0_r <= ~rd0_r;
            end
            case ({push0_s, pop0_s})
                2'b10:   count0_r <= count0_r + 2'd1;
                2'b01:   count0_r <= count0_r - 2'd1;
                default: count0_r <= count0_r;
            endcase
        end
    end

    // Output 1 FIFO: storage, wrapping pointers and occupancy count.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            mem1_r[0] <= '0;
            mem1_r[1] <= '0;
            wr1_r     <= 1'b0;
            rd1_r     <= 1'b0;
            count1_r  <= 2'd0;
        end else begin
            if (push1_s) begin
                mem1_r[wr1_r] <= data_i;
                wr1_r         <= ~wr1_r;
            end
            if (pop1_s) begin
                rd1_r <= ~rd1_r;
            end
            case ({push1_s, pop1_s})
                2'b10:   count1_r <= count1_r + 2'd1;
                2'b01:   count1_r <= count1_r - 2'd1;
                default: count1_r <= count1_r;
            endcase
        end
    end

    assign ready_o  = ready_s;
    assign valid0_o = (count0_r != 2'd0);
    assign valid1_o = (count1_r != 2'd0);
    assign data0_o  = mem0_r[rd0_r];
    assign data1_o  = mem1_r[rd1_r];

`ifdef STREAM_DEMUX_STATS_EN
    logic [15:0] cnt0_r;
    logic [15:0] cnt1_r;

    // Saturating delivery counters, one per output, stepped on each pop.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            cnt0_r <= 16'd0;
            cnt1_r <= 16'd0;
        end else begin
            if (pop0_s && (cnt0_r != 16'hFFFF)) begin
                cnt0_r <= cnt0_r + 16'd1;
            end
            if (pop1_s && (cnt1_r != 16'hFFFF)) begin
                cnt1_r <= cnt1_r + 16'd1;
            end
        end
    end

    assign cnt0_o = cnt0_r;
    assign cnt1_o = cnt1_r;
`endif

endmodule

// File: tb/tb_stream_demux_1to2.sv
// Directed self-checking bench for stream_demux_1to2 with a per-output
// scoreboard: accepted words are queued at the handshake and compared in
// order when the matching output pops.

module tb_stream_demux_1to2;

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic [31:0] data_i;
    logic        valid_i;
    logic        select_i;
    logic        ready_o;
    logic [31:0] data0_o;
    logic        valid0_o;
    logic        ready0_i;
    logic [31:0] data1_o;
    logic        valid1_o;
    logic        ready1_i;
`ifdef STREAM_DEMUX_STATS_EN
    logic [15:0] cnt0_o;
    logic [15:0] cnt1_o;
`endif

    int checks = 0;
    int errors = 0;
    logic [31:0] exp0 [$];
    logic [31:0] exp1 [$];

    stream_demux_1to2 #(.size(32)) dut (
        .clk_i    (clk_i),
        .rst_i    (rst_i),
        .data_i   (data_i),
        .valid_i  (valid_i),
        .select_i (select_i),
        .ready_o  (ready_o),
        .data0_o  (data0_o),
        .valid0_o (valid0_o),
        .ready0_i (ready0_i),
        .data1_o  (data1_o),
        .valid1_o (valid1_o),
        .ready1_i (ready1_i)
`ifdef STREAM_DEMUX_STATS_EN
        ,
        .cnt0_o   (cnt0_o),
        .cnt1_o   (cnt1_o)
`endif
    );

    always #5 clk_i = ~clk_i;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic v, input logic sel, input logic [31:0] d,
                         input logic r0, input logic r1);
        valid_i  = v;
        select_i = sel;
        data_i   = d;
        ready0_i = r0;
        ready1_i = r1;
        #1;
    endtask

    // One clock cycle: score pops and pushes mid-cycle, then advance past the edge.
    task automatic tick();
        #3;
        if (rst_i) begin
            exp0.delete();
            exp1.delete();
        end else begin
            if (valid0_o && ready0_i) begin
                chk("out0_word_expected", 32'(exp0.size() != 0), 32'd1);
                if (exp0.size() != 0) chk("out0_data_order", data0_o, exp0.pop_front());
            end
            if (valid1_o && ready1_i) begin
                chk("out1_word_expected", 32'(exp1.size() != 0), 32'd1);
                if (exp1.size() != 0) chk("out1_data_order", data1_o, exp1.pop_front());
            end
            if (valid_i && ready_o) begin
                if (select_i) exp1.push_back(data_i);
                else          exp0.push_back(data_i);
            end
        end
        @(posedge clk_i);
        #1;
    endtask

    initial begin
        // Reset
        rst_i = 1'b1;
        drive(1'b0, 1'b0, 32'd0, 1'b0, 1'b0);
        tick();
        tick();
        rst_i = 1'b0;
        drive(1'b0, 1'b0, 32'd0, 1'b0, 1'b0);
        chk("rst_valid0", 32'(valid0_o), 32'd0);
        chk("rst_valid1", 32'(valid1_o), 32'd0);
        chk("rst_data0", data0_o, 32'd0);
        chk("rst_data1", data1_o, 32'd0);
        chk("rst_ready_sel0", 32'(ready_o), 32'd1);
        drive(1'b0, 1'b1, 32'd0, 1'b0, 1'b0);
        chk("rst_ready_sel1", 32'(ready_o), 32'd1);
`ifdef STREAM_DEMUX_STATS_EN
        chk("rst_cnt0", 32'(cnt0_o), 32'd0);
        chk("rst_cnt1", 32'(cnt1_o), 32'd0);
`endif

        // Single word to output 1
        drive(1'b1, 1'b1, 32'hA5A5_0001, 1'b0, 1'b1);
        chk("single_ready", 32'(ready_o), 32'd1);
        tick();
        drive(1'b0, 1'b0, 32'd0, 1'b0, 1'b1);
        chk("single_valid1", 32'(valid1_o), 32'd1);
        chk("single_data1", data1_o, 32'hA5A5_0001);
        chk("single_valid0", 32'(valid0_o), 32'd0);
        tick();
        chk("single_drained", 32'(valid1_o), 32'd0);

        // Stall/full on output 0
        drive(1'b1, 1'b0, 32'd1, 1'b0, 1'b0);
        chk("full_ready_w1", 32'(ready_o), 32'd1);
        tick();
        drive(1'b1, 1'b0, 32'd2, 1'b0, 1'b0);
        chk("full_ready_w2", 32'(ready_o), 32'd1);
        tick();
        drive(1'b1, 1'b0, 32'd3, 1'b0, 1'b0);
        chk("full_ready_w3", 32'(ready_o), 32'd0);
        tick();
        chk("full_hold_ready", 32'(ready_o), 32'd0);
        chk("full_head", data0_o, 32'd1);
        drive(1'b1, 1'b0, 32'd3, 1'b1, 1'b0);
        chk("full_no_bypass", 32'(ready_o), 32'd0);
        tick();
        chk("full_after_pop_ready", 32'(ready_o), 32'd1);
        chk("full_head2", data0_o, 32'd2);
        tick();
        drive(1'b0, 1'b0, 32'd0, 1'b1, 1'b0);
        chk("full_head3", data0_o, 32'd3);
        tick();
        chk("full_empty", 32'(valid0_o), 32'd0);

        // Isolation: output 0 full and stalled, output 1 streams at 1/cycle
        drive(1'b1, 1'b0, 32'd10, 1'b0, 1'b1);
        tick();
        drive(1'b1, 1'b0, 32'd11, 1'b0, 1'b1);
        tick();
        for (int i = 0; i < 4; i++) begin
            drive(1'b1, 1'b1, 32'd20 + 32'(i), 1'b0, 1'b1);
            chk("iso_ready1", 32'(ready_o), 32'd1);
            tick();
            chk("iso_valid1", 32'(valid1_o), 32'd1);
            chk("iso_data1", data1_o, 32'd20 + 32'(i));
        end
        drive(1'b1, 1'b0, 32'd99, 1'b0, 1'b1);
        chk("iso_ready0_blocked", 32'(ready_o), 32'd0);
        tick();
        drive(1'b0, 1'b0, 32'd0, 1'b1, 1'b1);
        tick();
        tick();
        tick();
        chk("iso_empty0", 32'(valid0_o), 32'd0);
        chk("iso_empty1", 32'(valid1_o), 32'd0);

        // Simultaneous push and pop on output 0
        drive(1'b1, 1'b0, 32'd30, 1'b1, 1'b0);
        tick();
        drive(1'b1, 1'b0, 32'd31, 1'b1, 1'b0);
        chk("pp_ready", 32'(ready_o), 32'd1);
        chk("pp_head", data0_o, 32'd30);
        tick();
        drive(1'b0, 1'b0, 32'd0, 1'b1, 1'b0);
        chk("pp_valid", 32'(valid0_o), 32'd1);
        chk("pp_next", data0_o, 32'd31);
        tick();
        chk("pp_count1_drained", 32'(valid0_o), 32'd0);

        // Reset mid-stream with both FIFOs full
        drive(1'b1, 1'b0, 32'd40, 1'b0, 1'b0);
        tick();
        drive(1'b1, 1'b0, 32'd41, 1'b0, 1'b0);
        tick();
        drive(1'b1, 1'b1, 32'd50, 1'b0, 1'b0);
        tick();
        drive(1'b1, 1'b1, 32'd51, 1'b0, 1'b0);
        tick();
        chk("mid_full1", 32'(ready_o), 32'd0);
        drive(1'b1, 1'b0, 32'd52, 1'b0, 1'b0);
        chk("mid_full0", 32'(ready_o), 32'd0);
        rst_i = 1'b1;
        drive(1'b1, 1'b1, 32'd77, 1'b1, 1'b1);
        tick();
        rst_i = 1'b0;
        drive(1'b0, 1'b0, 32'd0, 1'b1, 1'b1);
        chk("mid_valid0", 32'(valid0_o), 32'd0);
        chk("mid_valid1", 32'(valid1_o), 32'd0);
        chk("mid_ready", 32'(ready_o), 32'd1);
        tick();
        tick();
        chk("mid_no_old0", 32'(valid0_o), 32'd0);
        chk("mid_no_old1", 32'(valid1_o), 32'd0);

`ifdef STREAM_DEMUX_STATS_EN
        // Delivery counters: 5 words on output 0, 3 on output 1
        chk("stat_cnt0_after_rst", 32'(cnt0_o), 32'd0);
        for (int i = 0; i < 5; i++) begin
            drive(1'b1, 1'b0, 32'd100 + 32'(i), 1'b1, 1'b1);
            tick();
            if (i < 3) begin
                drive(1'b1, 1'b1, 32'd200 + 32'(i), 1'b1, 1'b1);
                tick();
            end
        end
        drive(1'b0, 1'b0, 32'd0, 1'b1, 1'b1);
        tick();
        tick();
        chk("stat_cnt0", 32'(cnt0_o), 32'd5);
        chk("stat_cnt1", 32'(cnt1_o), 32'd3);

        // Saturation: 65535+ pops on output 0
        for (int i = 0; i < 65535; i++) begin
            drive(1'b1, 1'b0, 32'(i), 1'b1, 1'b0);
            tick();
        end
        drive(1'b0, 1'b0, 32'd0, 1'b1, 1'b0);
        tick();
        chk("stat_sat_cnt0", 32'(cnt0_o), 32'h0000_FFFF);
        drive(1'b1, 1'b0, 32'd5, 1'b1, 1'b0);
        tick();
        drive(1'b0, 1'b0, 32'd0, 1'b1, 1'b0);
        tick();
        chk("stat_sat_hold", 32'(cnt0_o), 32'h0000_FFFF);
        chk("stat_cnt1_unchanged", 32'(cnt1_o), 32'd3);
`endif

        chk("sb0_drained", 32'(exp0.size()), 32'd0);
        chk("sb1_drained", 32'(exp1.size()), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
